// File: rtl/writeback_stage.sv
// Final pipeline stage: commits ALU results and aligned load data to the register file,
// and keeps a one-cycle forwarding copy of the last write plus a retire counter.
module writeback_stage #(
  parameter int XW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mem_valid_ip,
  output logic          mem_ready_op,
  input  logic [4:0]    mem_rd_ip,
  input  logic          mem_reg_wr_ip,
  input  logic          mem_is_load_ip,
  input  logic [2:0]    mem_funct3_ip,
  input  logic [XW-1:0] mem_result_ip,
  input  logic          dmem_rvalid_ip,
  input  logic [XW-1:0] dmem_rdata_ip,
  output logic          wr_en_op,
  output logic [4:0]    wr_addr_op,
  output logic [XW-1:0] wr_data_op,
  output logic          fwd_valid_op,
  output logic [4:0]    fwd_addr_op,
  output logic [XW-1:0] fwd_data_op,
  output logic          err_op,
  output logic [31:0]   retired_count_op
);

  typedef enum logic {IDLE = 1'b0, WAIT_MEM = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [4:0]    ld_rd_q, ld_rd_d;
  logic [2:0]    ld_f3_q, ld_f3_d;
  logic [1:0]    ld_a_q, ld_a_d;
  logic          ld_wr_q, ld_wr_d;
  logic          wr_en_q, wr_en_d;
  logic [4:0]    wr_addr_q, wr_addr_d;
  logic [XW-1:0] wr_data_q, wr_data_d;
  logic          fwd_valid_q, fwd_valid_d;
  logic [4:0]    fwd_addr_q, fwd_addr_d;
  logic [XW-1:0] fwd_data_q, fwd_data_d;
  logic          err_q, err_d;
  logic [31:0]   cnt_q, cnt_d;

  logic          ld_err;
  logic [XW-1:0] byte_sh, half_sh, ld_data;

  assign mem_ready_op = (state_q == IDLE);

  // Legality of a load, judged on its funct3 and the low address bits.
  always_comb begin
    ld_err = 1'b0;
    case (mem_funct3_ip)
      3'b000, 3'b100: ld_err = 1'b0;
      3'b001, 3'b101: ld_err = mem_result_ip[0];
      3'b010:         ld_err = |mem_result_ip[1:0];
      default:        ld_err = 1'b1;
    endcase
  end

  always_comb begin
    byte_sh = dmem_rdata_ip >> {ld_a_q, 3'b000};
    half_sh = dmem_rdata_ip >> {ld_a_q[1], 4'b0000};
    case (ld_f3_q)
      3'b000:  ld_data = {{(XW-8){byte_sh[7]}}, byte_sh[7:0]};
      3'b100:  ld_data = {{(XW-8){1'b0}}, byte_sh[7:0]};
      3'b001:  ld_data = {{(XW-16){half_sh[15]}}, half_sh[15:0]};
      3'b101:  ld_data = {{(XW-16){1'b0}}, half_sh[15:0]};
      default: ld_data = dmem_rdata_ip;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    ld_rd_d     = ld_rd_q;
    ld_f3_d     = ld_f3_q;
    ld_a_d      = ld_a_q;
    ld_wr_d     = ld_wr_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    err_d       = 1'b0;
    cnt_d       = cnt_q;
    fwd_valid_d = wr_en_q;
    fwd_addr_d  = wr_en_q ? wr_addr_q : fwd_addr_q;
    fwd_data_d  = wr_en_q ? wr_data_q : fwd_data_q;
    case (state_q)
      IDLE: begin
        if (mem_valid_ip) begin
          if (!mem_is_load_ip) begin
            wr_en_d   = mem_reg_wr_ip && (mem_rd_ip != 5'd0);
            wr_addr_d = mem_rd_ip;
            wr_data_d = mem_result_ip;
            cnt_d     = cnt_q + 32'd1;
          end else if (ld_err) begin
            err_d = 1'b1;
          end else begin
            ld_rd_d = mem_rd_ip;
            ld_f3_d = mem_funct3_ip;
            ld_a_d  = mem_result_ip[1:0];
            ld_wr_d = mem_reg_wr_ip;
            state_d = WAIT_MEM;
          end
        end
      end
      WAIT_MEM: begin
        if (dmem_rvalid_ip) begin
          wr_en_d   = ld_wr_q && (ld_rd_q != 5'd0);
          wr_addr_d = ld_rd_q;
          wr_data_d = ld_data;
          cnt_d     = cnt_q + 32'd1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ld_rd_q     <= '0;
      ld_f3_q     <= '0;
      ld_a_q      <= '0;
      ld_wr_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      fwd_valid_q <= 1'b0;
      fwd_addr_q  <= '0;
      fwd_data_q  <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ld_rd_q     <= ld_rd_d;
      ld_f3_q     <= ld_f3_d;
      ld_a_q      <= ld_a_d;
      ld_wr_q     <= ld_wr_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      fwd_valid_q <= fwd_valid_d;
      fwd_addr_q  <= fwd_addr_d;
      fwd_data_q  <= fwd_data_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign wr_en_op         = wr_en_q;
  assign wr_addr_op       = wr_addr_q;
  assign wr_data_op       = wr_data_q;
  assign fwd_valid_op     = fwd_valid_q;
  assign fwd_addr_op      = fwd_addr_q;
  assign fwd_data_op      = fwd_data_q;
  assign err_op           = err_q;
  assign retired_count_op = cnt_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed + randomized bench for writeback_stage against a transaction-level reference model.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid_ip, mem_ready_op, mem_reg_wr_ip, mem_is_load_ip;
  logic [4:0]  mem_rd_ip;
  logic [2:0]  mem_funct3_ip;
  logic [31:0] mem_result_ip;
  logic        dmem_rvalid_ip;
  logic [31:0] dmem_rdata_ip;
  logic        wr_en_op, fwd_valid_op, err_op;
  logic [4:0]  wr_addr_op, fwd_addr_op;
  logic [31:0] wr_data_op, fwd_data_op, retired_count_op;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  writeback_stage #(.XW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid_ip(mem_valid_ip), .mem_ready_op(mem_ready_op),
    .mem_rd_ip(mem_rd_ip), .mem_reg_wr_ip(mem_reg_wr_ip),
    .mem_is_load_ip(mem_is_load_ip), .mem_funct3_ip(mem_funct3_ip),
    .mem_result_ip(mem_result_ip),
    .dmem_rvalid_ip(dmem_rvalid_ip), .dmem_rdata_ip(dmem_rdata_ip),
    .wr_en_op(wr_en_op), .wr_addr_op(wr_addr_op), .wr_data_op(wr_data_op),
    .fwd_valid_op(fwd_valid_op), .fwd_addr_op(fwd_addr_op), .fwd_data_op(fwd_data_op),
    .err_op(err_op), .retired_count_op(retired_count_op)
  );

  // Reference model state: pending load plus what the register-file port should show.
  bit          m_busy;
  bit [4:0]    m_rd;
  bit [2:0]    m_f3;
  bit [1:0]    m_a;
  bit          m_wr;
  bit          m_wr_en, m_fwd_v, m_err;
  bit [4:0]    m_wr_a, m_fwd_a;
  bit [31:0]   m_wr_d, m_fwd_d, m_cnt;

  function automatic bit load_ok(input bit [2:0] f3, input bit [1:0] a);
    if (f3 == 3'd0 || f3 == 3'd4) return 1'b1;
    if (f3 == 3'd1 || f3 == 3'd5) return (a % 2) == 0;
    if (f3 == 3'd2) return a == 0;
    return 1'b0;
  endfunction

  function automatic bit [31:0] load_val(input bit [2:0] f3, input bit [1:0] a, input bit [31:0] w);
    bit [31:0] v;
    case (f3)
      3'd0, 3'd4: begin
        v = (w / (32'd1 << (8 * a))) % 32'd256;
        if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
      end
      3'd1, 3'd5: begin
        v = (w / (32'd1 << (16 * (a / 2)))) % 32'd65536;
        if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock with the current inputs, update the model, compare everything.
  task automatic cycle();
    bit n_busy, n_en, n_err, n_fv;
    bit [4:0] n_a, n_fa;
    bit [31:0] n_d, n_fd, n_cnt;
    n_busy = m_busy; n_en = 1'b0; n_err = 1'b0; n_a = m_wr_a; n_d = m_wr_d; n_cnt = m_cnt;
    n_fv = m_wr_en; n_fa = m_wr_en ? m_wr_a : m_fwd_a; n_fd = m_wr_en ? m_wr_d : m_fwd_d;
    if (!rst_n) begin
      n_busy = 0; n_a = 0; n_d = 0; n_cnt = 0; n_fv = 0; n_fa = 0; n_fd = 0;
    end else if (m_busy) begin
      if (dmem_rvalid_ip) begin
        n_en = m_wr && m_rd != 0; n_a = m_rd; n_d = load_val(m_f3, m_a, dmem_rdata_ip);
        n_cnt = m_cnt + 1; n_busy = 0;
      end
    end else if (mem_valid_ip) begin
      if (!mem_is_load_ip) begin
        n_en = mem_reg_wr_ip && mem_rd_ip != 0; n_a = mem_rd_ip; n_d = mem_result_ip;
        n_cnt = m_cnt + 1;
      end else if (!load_ok(mem_funct3_ip, mem_result_ip[1:0])) begin
        n_err = 1'b1;
      end else begin
        n_busy = 1; m_rd = mem_rd_ip; m_f3 = mem_funct3_ip; m_a = mem_result_ip[1:0];
        m_wr = mem_reg_wr_ip;
      end
    end
    @(posedge clk); #1;
    m_busy = n_busy; m_wr_en = n_en; m_err = n_err; m_wr_a = n_a; m_wr_d = n_d; m_cnt = n_cnt;
    m_fwd_v = n_fv; m_fwd_a = n_fa; m_fwd_d = n_fd;
    chk("ready", {31'd0, mem_ready_op}, {31'd0, !m_busy});
    chk("wr_en", {31'd0, wr_en_op}, {31'd0, m_wr_en});
    if (m_wr_en) begin
      chk("wr_addr", {27'd0, wr_addr_op}, {27'd0, m_wr_a});
      chk("wr_data", wr_data_op, m_wr_d);
    end
    chk("err", {31'd0, err_op}, {31'd0, m_err});
    chk("count", retired_count_op, m_cnt);
    chk("fwd_valid", {31'd0, fwd_valid_op}, {31'd0, m_fwd_v});
    chk("fwd_addr", {27'd0, fwd_addr_op}, {27'd0, m_fwd_a});
    chk("fwd_data", fwd_data_op, m_fwd_d);
  endtask

  task automatic idle();
    mem_valid_ip = 0; dmem_rvalid_ip = 0;
  endtask

  task automatic nonload(input bit [4:0] rd, input bit [31:0] res, input bit wr);
    mem_valid_ip = 1; mem_is_load_ip = 0; mem_rd_ip = rd; mem_result_ip = res;
    mem_reg_wr_ip = wr; mem_funct3_ip = 3'd0; dmem_rvalid_ip = 0;
    cycle();
    idle();
  endtask

  task automatic load(input bit [4:0] rd, input bit [2:0] f3, input bit [31:0] addr);
    mem_valid_ip = 1; mem_is_load_ip = 1; mem_rd_ip = rd; mem_result_ip = addr;
    mem_reg_wr_ip = 1; mem_funct3_ip = f3; dmem_rvalid_ip = 1; dmem_rdata_ip = 32'hDEAD_BEEF;
    cycle();
    idle();
  endtask

  task automatic respond(input int delay, input bit [31:0] rdata);
    idle();
    for (int i = 0; i < delay; i++) cycle();
    dmem_rvalid_ip = 1; dmem_rdata_ip = rdata;
    cycle();
    idle();
  endtask

  initial begin
    rst_n = 0; idle(); mem_rd_ip = 0; mem_reg_wr_ip = 0; mem_is_load_ip = 0;
    mem_funct3_ip = 0; mem_result_ip = 0; dmem_rdata_ip = 0;
    m_busy = 1; m_wr_en = 0;
    cycle(); cycle();
    chk("rst_wr_addr", {27'd0, wr_addr_op}, 32'd0);
    chk("rst_wr_data", wr_data_op, 32'd0);
    rst_n = 1;

    nonload(5'd5, 32'h1234_5678, 1'b1);
    chk("tp_nl_data", wr_data_op, 32'h1234_5678);
    chk("tp_nl_count", retired_count_op, 32'd1);
    cycle();
    chk("tp_fwd_data", fwd_data_op, 32'h1234_5678);

    load(5'd7, 3'd0, 32'h0000_0101);
    respond(3, 32'hAABB_80CC);
    chk("tp_lb", wr_data_op, 32'hFFFF_FF80);
    load(5'd7, 3'd4, 32'h0000_0101);
    respond(3, 32'hAABB_80CC);
    chk("tp_lbu", wr_data_op, 32'h0000_0080);
    load(5'd8, 3'd5, 32'h0000_0202);
    respond(1, 32'h8001_0000);
    chk("tp_lhu", wr_data_op, 32'h0000_8001);
    load(5'd9, 3'd1, 32'h0000_0203);
    chk("tp_lh_err", {31'd0, err_op}, 32'd1);
    cycle();

    nonload(5'd0, 32'hCAFE_F00D, 1'b1);
    load(5'd3, 3'd3, 32'h0000_0100);
    chk("tp_f3_err", {31'd0, err_op}, 32'd1);
    cycle();

    rst_n = 0; cycle(); rst_n = 1;
    for (int r = 1; r <= 4; r++) begin
      mem_valid_ip = 1; mem_is_load_ip = 0; mem_rd_ip = 5'(r); mem_reg_wr_ip = 1;
      mem_result_ip = 32'h100 + 32'(r);
      cycle();
      chk("b2b_addr", {27'd0, wr_addr_op}, 32'(r));
    end
    idle();
    chk("b2b_count", retired_count_op, 32'd4);
    cycle();

    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    m_cnt = 32'hFFFF_FFFF;
    cycle();
    nonload(5'd6, 32'h55, 1'b1);
    chk("wrap", retired_count_op, 32'd0);

    load(5'd10, 3'd2, 32'h0000_0400);
    cycle();
    rst_n = 0; cycle(); rst_n = 1;
    dmem_rvalid_ip = 1; dmem_rdata_ip = 32'h1111_2222;
    cycle(); idle(); cycle();
    chk("rst_wait_wr_en", {31'd0, wr_en_op}, 32'd0);
    chk("rst_wait_ready", {31'd0, mem_ready_op}, 32'd1);
    chk("rst_wait_fwd", fwd_data_op, 32'd0);

    for (int n = 0; n < 600; n++) begin
      rst_n          = ($urandom_range(0, 99) != 0);
      mem_valid_ip   = $urandom_range(0, 2) != 0;
      mem_is_load_ip = $urandom_range(0, 1) == 1;
      mem_rd_ip      = 5'($urandom_range(0, 31));
      mem_reg_wr_ip  = $urandom_range(0, 3) != 0;
      mem_funct3_ip  = 3'($urandom_range(0, 7));
      mem_result_ip  = $urandom;
      dmem_rvalid_ip = $urandom_range(0, 2) == 0;
      dmem_rdata_ip  = $urandom;
      cycle();
    end
    rst_n = 1; idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final CPU pipeline stage; sits directly upstream of the register file and drives its write port.
- Accepts retiring instructions from the memory stage over a valid/ready handshake.
- For loads, waits for the data-memory response, then aligns and sign/zero-extends it.
- Provides a one-cycle forwarding copy of the last write, covering the register file's registered-read latency, plus a retired-instruction counter.

Parameters:
XW, 32, datapath width (bits); fixed-function logic assumes XW=32

Ports:
clk  input  1  clock; all state on rising edge
rst_n  input  1  reset, synchronous, active-low
mem_valid_ip  input  1  memory stage presents an instruction
mem_ready_op  output  1  stage can accept (1 in IDLE, 0 in WAIT_MEM)
mem_rd_ip  input  5  destination register
mem_reg_wr_ip  input  1  instruction writes rd
mem_is_load_ip  input  1  instruction is a load
mem_funct3_ip  input  3  load size/sign (LB 000, LH 001, LW 010, LBU 100, LHU 101)
mem_result_ip  input  XW  ALU result; for loads, the effective byte address
dmem_rvalid_ip  input  1  data-memory read response valid
dmem_rdata_ip  input  XW  data-memory read word (word-aligned)
wr_en_op  output  1  register file write enable
wr_addr_op  output  5  register file write address
wr_data_op  output  XW  register file write data
fwd_valid_op  output  1  forwarding entry valid
fwd_addr_op  output  5  forwarded register
fwd_data_op  output  XW  forwarded data
err_op  output  1  one-cycle pulse: illegal funct3 or misaligned load
retired_count_op  output  32  committed-instruction count, wraps

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE.
  - wr_en_op, fwd_valid_op and err_op go to 0.
  - wr_addr_op, wr_data_op, fwd_addr_op and fwd_data_op go to 0.
  - retired_count_op goes to 0.
  - Reset overrides everything; a load in WAIT_MEM is abandoned.
- Handshake:
  - An instruction is accepted on an edge where mem_valid_ip=1 and mem_ready_op=1.
  - mem_ready_op is combinational from state only.
- States:
  - IDLE: accepts the instruction.
    - Non-load: stays in IDLE.
    - Legal, aligned load: latch rd, funct3, address bits [1:0] and reg_wr, then go to WAIT_MEM.
    - Illegal or misaligned load: stays in IDLE.
  - WAIT_MEM: mem_ready_op=0. On dmem_rvalid_ip=1, go to IDLE. Otherwise stay in WAIT_MEM indefinitely.
  - dmem_rvalid_ip is ignored in IDLE, including in the cycle a load is accepted. The earliest usable response is the cycle after acceptance.
- Write timing (all outputs registered; wr_en_op, err_op and the retire increment are one-cycle pulses):
  - Non-load: on the acceptance edge, wr_en_op <= reg_wr && rd!=0, wr_addr_op <= rd, wr_data_op <= result. This gives 1-cycle latency.
  - Load: on the rvalid edge, a write of the extracted data (rules below) under the same rd!=0 gating. This gives 1-cycle latency from response.
  - Back-to-back non-loads give one write per cycle.
- Load extraction (a = latched address bits [1:0]):
  - LB/LBU: byte at dmem_rdata_ip[8a+7:8a], sign/zero-extended.
  - LH/LHU: half at [16a[1]+15:16a[1]], sign/zero-extended.
  - LW: full word.
- Errors (checked at acceptance):
  - Load with funct3 in {011,110,111}: error.
  - LH/LHU with a[0]=1: error.
  - LW with a!=0: error.
  - On error: err_op=1 for the next cycle, no write, no WAIT_MEM, not counted as retired.
  - The err_op check is skipped for non-loads.
- Retire:
  - retired_count_op increments by 1 in the cycle a write slot occurs: non-load accept, or load rvalid.
  - It counts regardless of reg_wr or rd==0.
  - It wraps from 0xFFFFFFFF to 0.
- Forwarding:
  - Whenever wr_en_op=1 on an edge, the next cycle has fwd_valid_op=1, fwd_addr_op=wr_addr_op and fwd_data_op=wr_data_op.
  - Otherwise fwd_valid_op is 0; fwd_addr_op and fwd_data_op hold.
- Writes to x0 never assert wr_en_op and never create a forwarding entry.

Test Plan:
- Reset, then accept non-load rd=5, result=0x1234_5678, reg_wr=1 -> next cycle wr_en_op=1, addr 5, data 0x12345678, count=1. Cycle after: fwd_valid_op=1, addr 5, data 0x12345678.
- Load LB, addr ...01, rvalid 3 cycles later with rdata 0xAABB80CC -> mem_ready_op=0 for 3 cycles. Write data 0xFFFFFF80. Repeat as LBU -> 0x00000080.
- LHU addr ...10 with rdata 0x8001_0000 -> 0x00008001. LH at addr ...11 -> err_op pulse, no write, count unchanged, mem_ready_op stays 1.
- Non-load rd=0, reg_wr=1 -> wr_en_op=0, fwd_valid_op=0, count increments. Repeat with funct3=011 load -> err_op=1, no write.
- Four back-to-back non-loads (rd 1..4) -> four consecutive wr_en_op cycles in order, count=4. Then force count to 0xFFFFFFFF via 2^32-1 retires (or backdoor) -> next retire gives 0.
- Assert rst_n=0 while in WAIT_MEM, then drive rvalid -> no write, mem_ready_op=1, all outputs 0.
